// File: rtl/sqrt_pkg.sv
// Shared definitions for the sequential FP16 square-root controller:
// controller state encoding, FP16 special encodings and the default core step count.
package sqrt_pkg;

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_CLASSIFY = 3'd1,
      S_WAIT_CLS = 3'd2,
      S_ITER     = 3'd3,
      S_PACK     = 3'd4,
      S_OUTPUT   = 3'd5
   } state_t;

   localparam logic [4:0]  EXP_MAX        = 5'h1F;
   localparam logic [15:0] QNAN_NEG       = 16'hFE00;
   localparam logic [15:0] PINF           = 16'h7C00;
   localparam int          ITER_STEPS_DEF = 12;

endpackage

// File: rtl/sqrt_seq.sv
// Sequencer for an FP16 square root: hands the operand to an external special-case
// stage, bypasses NaN/inf/zero/negative results, otherwise runs an external iteration core.
module sqrt_seq
   import sqrt_pkg::*;
#(
   parameter int ITER_STEPS = ITER_STEPS_DEF
) (
   input  logic        clk,
   input  logic        rst,
   // Handshakes: a transfer happens on a rising clk edge where valid and ready are both high;
   // the source holds valid and data steady until that edge.
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [15:0] in_data,
   output logic        sp_enable,
   output logic        sp_valid,
   input  logic        sp_s_valid,
   output logic        sp_sign,
   output logic [4:0]  sp_exp,
   output logic [9:0]  sp_mant,
   input  logic        sp_is_nan,
   input  logic        sp_is_pinf,
   input  logic        sp_is_ninf,
   input  logic        sp_is_normal,
   input  logic        sp_is_subnormal,
   input  logic        sp_sign_out,
   input  logic [4:0]  sp_exp_out,
   input  logic [9:0]  sp_mant_out,
   output logic        it_start,
   output logic        it_step,
   output logic [15:0] it_operand,
   input  logic [15:0] it_result,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] out_data,
   output logic        out_special,
   output logic        busy,
   output logic [2:0]  dbg_state
);

   localparam int               CNT_W    = $clog2(ITER_STEPS + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER_STEPS - 1);

   state_t             state_q, state_d;
   logic [15:0]        operand_q, operand_d;
   logic [15:0]        it_operand_q, it_operand_d;
   logic [15:0]        out_data_q, out_data_d;
   logic               out_special_q, out_special_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               in_ready_q, in_ready_d;
   logic               busy_q, busy_d;
   logic               sp_enable_q, sp_enable_d;
   logic               sp_valid_q, sp_valid_d;
   logic               it_start_q, it_start_d;
   logic               it_step_q, it_step_d;
   logic               out_valid_q, out_valid_d;

   logic [15:0]        sp_result;
   logic               res_zero;
   logic               res_nan;
   logic               bypass;
   logic [15:0]        byp_data;

   always_comb begin
      state_d       = state_q;
      operand_d     = operand_q;
      it_operand_d  = it_operand_q;
      out_data_d    = out_data_q;
      out_special_d = out_special_q;
      cnt_d         = cnt_q;

      sp_result = {sp_sign_out, sp_exp_out, sp_mant_out};
      res_zero  = (sp_exp_out == 5'd0) && (sp_mant_out == 10'd0);
      res_nan   = sp_is_nan || ((sp_exp_out == EXP_MAX) && (sp_mant_out != 10'd0));

      // Priority: NaN, -inf, +inf, signed zero; only positive finite non-zero values
      // reach the core, anything else negative is an invalid operation.
      bypass   = 1'b1;
      byp_data = QNAN_NEG;
      if (res_nan) begin
         byp_data = sp_result;
      end else if (sp_is_ninf) begin
         byp_data = QNAN_NEG;
      end else if (sp_is_pinf) begin
         byp_data = PINF;
      end else if (res_zero) begin
         byp_data = sp_result;
      end else if (!sp_sign_out && (sp_is_normal || sp_is_subnormal)) begin
         bypass = 1'b0;
      end

      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               operand_d = in_data;
               state_d   = S_CLASSIFY;
            end
         end
         S_CLASSIFY: state_d = S_WAIT_CLS;
         S_WAIT_CLS: begin
            if (sp_s_valid) begin
               if (bypass) begin
                  out_data_d    = byp_data;
                  out_special_d = 1'b1;
                  state_d       = S_OUTPUT;
               end else begin
                  it_operand_d = sp_result;
                  cnt_d        = '0;
                  state_d      = S_ITER;
               end
            end
         end
         S_ITER: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) begin
               state_d = S_PACK;
            end
         end
         S_PACK: begin
            out_data_d    = it_result;
            out_special_d = 1'b0;
            state_d       = S_OUTPUT;
         end
         S_OUTPUT: begin
            if (out_ready) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Strobes are registered, so they are decoded from the state being entered.
      in_ready_d  = (state_d == S_IDLE);
      busy_d      = (state_d != S_IDLE);
      sp_enable_d = (state_d inside {S_CLASSIFY, S_WAIT_CLS, S_ITER, S_PACK});
      sp_valid_d  = (state_d == S_CLASSIFY);
      it_step_d   = (state_d == S_ITER);
      it_start_d  = (state_d == S_ITER) && (state_q != S_ITER);
      out_valid_d = (state_d == S_OUTPUT);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= S_IDLE;
         operand_q     <= '0;
         it_operand_q  <= '0;
         out_data_q    <= '0;
         out_special_q <= 1'b0;
         cnt_q         <= '0;
         in_ready_q    <= 1'b1;
         busy_q        <= 1'b0;
         sp_enable_q   <= 1'b0;
         sp_valid_q    <= 1'b0;
         it_start_q    <= 1'b0;
         it_step_q     <= 1'b0;
         out_valid_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         operand_q     <= operand_d;
         it_operand_q  <= it_operand_d;
         out_data_q    <= out_data_d;
         out_special_q <= out_special_d;
         cnt_q         <= cnt_d;
         in_ready_q    <= in_ready_d;
         busy_q        <= busy_d;
         sp_enable_q   <= sp_enable_d;
         sp_valid_q    <= sp_valid_d;
         it_start_q    <= it_start_d;
         it_step_q     <= it_step_d;
         out_valid_q   <= out_valid_d;
      end
   end

   assign sp_sign     = operand_q[15];
   assign sp_exp      = operand_q[14:10];
   assign sp_mant     = operand_q[9:0];
   assign in_ready    = in_ready_q;
   assign busy        = busy_q;
   assign sp_enable   = sp_enable_q;
   assign sp_valid    = sp_valid_q;
   assign it_start    = it_start_q;
   assign it_step     = it_step_q;
   assign it_operand  = it_operand_q;
   assign out_valid   = out_valid_q;
   assign out_data    = out_data_q;
   assign out_special = out_special_q;
   assign dbg_state   = state_q;

endmodule
